// File: rtl/iu_spr_file_pkg.sv
// Shared types and constants for the per-thread special-register table:
// thread-state layout, commit record, init values and the field-group widths.
package iu_spr_file_pkg;

   localparam int NTHREAD_CFG  = 64;
   localparam int NTHREADIDMSB = 5;
   localparam int NWIN         = 8;
   localparam int UPC_W        = 4;
   localparam int FLUSH_W      = 4;

   typedef struct packed {
      logic [3:0] icc;
      logic [3:0] pil;
      logic       ef;
      logic       s;
      logic       ps;
      logic       et;
      logic [2:0] cwp;
   } psr_type;

   typedef struct packed {
      logic [29:0]        pc;
      logic [29:0]        npc;
      psr_type            psr;
      logic [NWIN-1:0]    wim;
      logic [31:0]        y;
      logic               run;
      logic               valid;
      logic               replay;
      logic               annul;
      logic               ucmode;
      logic               dma_mode;
      logic               icmiss;
      logic [UPC_W-1:0]   upc;
      logic [FLUSH_W-1:0] flushidx;
   } spr_state_type;

   // a_* carry the architectural-commit view of psr, used when archr_we is set without psr_we
   typedef struct packed {
      logic          pc_we;
      logic          npc_we;
      logic          psr_we;
      logic          archr_we;
      logic          ts_we;
      logic [3:0]    a_icc;
      logic [3:0]    a_pil;
      logic          a_ef;
      spr_state_type st;
   } spr_commit_type;

   typedef enum logic {SPR_INIT, SPR_RUN} spr_fsm_e;

   localparam psr_type init_psr = '{icc: 4'h0, pil: 4'h0, ef: 1'b0, s: 1'b1,
                                    ps: 1'b0, et: 1'b0, cwp: 3'd0};
   localparam logic [31:0] init_y = 32'h0;
   localparam spr_state_type init_spr_state = '{pc: 30'h0, npc: 30'h1, psr: init_psr,
                                                y: init_y, default: '0};

   localparam int ARC_W  = 9;
   localparam int PSRX_W = 6;
   localparam int WY_W   = NWIN + 32;
   localparam int TS_W   = 7 + UPC_W + FLUSH_W;

   function automatic logic [TS_W-1:0] spr_ts_pack(spr_state_type s);
      return {s.run, s.valid, s.replay, s.annul, s.ucmode, s.dma_mode, s.icmiss,
              s.upc, s.flushidx};
   endfunction

endpackage

// File: rtl/iu_spr_file_bank.sv
// One field-group bank: 1W1R table, synchronous write, asynchronous read.
// The read value is registered by the owner, so the pair behaves read-first.
module iu_spr_bank #(
   parameter int W     = 1,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iu_spr_file.sv
// Per-thread special-register table. Self-initialises every entry after reset,
// then accepts per-group commits and serves one registered read per cycle.
module iu_spr_file
   import iu_spr_file_pkg::*;
#(
   parameter int unsigned NTHREAD  = NTHREAD_CFG,
   parameter logic [29:0] RESET_PC = 30'h0,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  rd_en,
   input  logic [NTHREADIDMSB:0] rd_tid,
   output logic                  rd_valid,
   output logic [NTHREADIDMSB:0] rd_tid_q,
   output spr_state_type         rd_state,
   input  logic [NTHREADIDMSB:0] wr_tid,
   input  spr_commit_type        wr,
   output logic                  init_busy
);

   localparam int TIDW = NTHREADIDMSB + 1;

   spr_fsm_e         state_q, state_d;
   logic [TIDW-1:0]  cnt_q, cnt_d;
   logic             init_act, byp;
   logic             rd_valid_q;
   spr_state_type    rd_state_q, tbl_rd, rd_d;

   logic [TIDW-1:0]  waddr;
   logic             we_pc, we_npc, we_arc, we_psrx, we_wy, we_ts;
   logic [29:0]      wd_pc, wd_npc, rt_pc, rt_npc;
   logic [ARC_W-1:0] wd_arc, rt_arc;
   logic [PSRX_W-1:0] wd_psrx, rt_psrx;
   logic [WY_W-1:0]  wd_wy, rt_wy;
   logic [TS_W-1:0]  wd_ts, rt_ts;

   assign init_act = (state_q == SPR_INIT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == SPR_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == TIDW'(NTHREAD - 1)) begin
            state_d = SPR_RUN;
            cnt_d   = '0;
         end
      end
   end

   // During the sweep every bank writes its init value at the counter address
   always_comb begin
      waddr   = init_act ? cnt_q : wr_tid;
      we_pc   = init_act | wr.pc_we;
      we_npc  = init_act | wr.npc_we;
      we_arc  = init_act | wr.psr_we | wr.archr_we;
      we_psrx = init_act | wr.psr_we;
      we_wy   = init_act | wr.archr_we;
      we_ts   = init_act | wr.ts_we;
      wd_pc   = init_act ? RESET_PC : wr.st.pc;
      wd_npc  = init_act ? RESET_PC + 30'd1 : wr.st.npc;
      if (init_act)
         wd_arc = {init_psr.icc, init_psr.pil, init_psr.ef};
      else if (wr.psr_we)
         wd_arc = {wr.st.psr.icc, wr.st.psr.pil, wr.st.psr.ef};
      else
         wd_arc = {wr.a_icc, wr.a_pil, wr.a_ef};
      wd_psrx = init_act ? {init_psr.s, init_psr.ps, init_psr.et, init_psr.cwp}
                         : {wr.st.psr.s, wr.st.psr.ps, wr.st.psr.et, wr.st.psr.cwp};
      wd_wy   = init_act ? {init_spr_state.wim, init_y} : {wr.st.wim, wr.st.y};
      wd_ts   = init_act ? spr_ts_pack(init_spr_state) : spr_ts_pack(wr.st);
   end

   iu_spr_bank #(.W(30),     .DEPTH(NTHREAD), .AW(TIDW)) u_pc   (.clk(clk), .we_i(we_pc),   .waddr_i(waddr), .wdata_i(wd_pc),   .raddr_i(rd_tid), .rdata_o(rt_pc));
   iu_spr_bank #(.W(30),     .DEPTH(NTHREAD), .AW(TIDW)) u_npc  (.clk(clk), .we_i(we_npc),  .waddr_i(waddr), .wdata_i(wd_npc),  .raddr_i(rd_tid), .rdata_o(rt_npc));
   iu_spr_bank #(.W(ARC_W),  .DEPTH(NTHREAD), .AW(TIDW)) u_arc  (.clk(clk), .we_i(we_arc),  .waddr_i(waddr), .wdata_i(wd_arc),  .raddr_i(rd_tid), .rdata_o(rt_arc));
   iu_spr_bank #(.W(PSRX_W), .DEPTH(NTHREAD), .AW(TIDW)) u_psrx (.clk(clk), .we_i(we_psrx), .waddr_i(waddr), .wdata_i(wd_psrx), .raddr_i(rd_tid), .rdata_o(rt_psrx));
   iu_spr_bank #(.W(WY_W),   .DEPTH(NTHREAD), .AW(TIDW)) u_wy   (.clk(clk), .we_i(we_wy),   .waddr_i(waddr), .wdata_i(wd_wy),   .raddr_i(rd_tid), .rdata_o(rt_wy));
   iu_spr_bank #(.W(TS_W),   .DEPTH(NTHREAD), .AW(TIDW)) u_ts   (.clk(clk), .we_i(we_ts),   .waddr_i(waddr), .wdata_i(wd_ts),   .raddr_i(rd_tid), .rdata_o(rt_ts));

   // In RUN the wd_* buses carry the commit data, so they double as bypass sources
   always_comb begin
      tbl_rd     = init_spr_state;
      tbl_rd.pc  = rt_pc;
      tbl_rd.npc = rt_npc;
      {tbl_rd.psr.icc, tbl_rd.psr.pil, tbl_rd.psr.ef} = rt_arc;
      {tbl_rd.psr.s, tbl_rd.psr.ps, tbl_rd.psr.et, tbl_rd.psr.cwp} = rt_psrx;
      {tbl_rd.wim, tbl_rd.y} = rt_wy;
      {tbl_rd.run, tbl_rd.valid, tbl_rd.replay, tbl_rd.annul, tbl_rd.ucmode,
       tbl_rd.dma_mode, tbl_rd.icmiss, tbl_rd.upc, tbl_rd.flushidx} = rt_ts;

      byp  = BYPASS && (rd_tid == wr_tid) && !init_act;
      rd_d = tbl_rd;
      if (byp) begin
         if (wr.pc_we)  rd_d.pc  = wd_pc;
         if (wr.npc_we) rd_d.npc = wd_npc;
         if (wr.psr_we || wr.archr_we)
            {rd_d.psr.icc, rd_d.psr.pil, rd_d.psr.ef} = wd_arc;
         if (wr.psr_we)
            {rd_d.psr.s, rd_d.psr.ps, rd_d.psr.et, rd_d.psr.cwp} = wd_psrx;
         if (wr.archr_we) {rd_d.wim, rd_d.y} = wd_wy;
         if (wr.ts_we)
            {rd_d.run, rd_d.valid, rd_d.replay, rd_d.annul, rd_d.ucmode,
             rd_d.dma_mode, rd_d.icmiss, rd_d.upc, rd_d.flushidx} = wd_ts;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= SPR_INIT;
         cnt_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_tid_q   <= '0;
         rd_state_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_valid_q <= rd_en & ~init_act;
         if (rd_en && !init_act) begin
            rd_tid_q   <= rd_tid;
            rd_state_q <= rd_d;
         end
      end
   end

   assign rd_valid  = rd_valid_q;
   assign rd_state  = rd_state_q;
   assign init_busy = init_act;

endmodule
